// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel |Gx|+|Gy| over two line buffers; 2-stage pipeline, stalls fully on m_ready low.
// Optional SOBEL_THRESH_EN adds a thresh port and turns the output into a binary edge map.
module sobel_stream #(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int PIX_W     = 8,
    parameter int MAG_SHIFT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] s_data,
    input  logic             s_sof,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [PIX_W-1:0] m_data,
    output logic             m_sof,
    output logic             m_eol,
    output logic             m_valid,
    input  logic             m_ready
`ifdef SOBEL_THRESH_EN
    ,
    input  logic [PIX_W-1:0] thresh
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int GW = PIX_W + 3;

    logic             en;
    logic             acc;
    logic [CW-1:0]    col;
    logic [CW-1:0]    cur_col;
    logic [RW-1:0]    row;
    logic [RW-1:0]    cur_row;

    logic [PIX_W-1:0] lb1 [IMG_W];
    logic [PIX_W-1:0] lb2 [IMG_W];
    logic [PIX_W-1:0] lb1_q;
    logic [PIX_W-1:0] lb2_q;

    logic [PIX_W-1:0] win [3][3];
    logic             v1;
    logic             sof1;
    logic             eol1;

    logic [GW-1:0]    gx;
    logic [GW-1:0]    gy;
    logic [GW-1:0]    gx_abs;
    logic [GW-1:0]    gy_abs;
    logic [GW-1:0]    mag;
    logic [GW-1:0]    mag_sh;
    logic [PIX_W-1:0] sat;
    logic [PIX_W-1:0] result;

    assign en      = !m_valid || m_ready;
    assign s_ready = en;
    assign acc     = s_valid && en;

    // A start-of-frame pixel is placed at (0,0) whatever the counters say.
    assign cur_col = s_sof ? '0 : col;
    assign cur_row = s_sof ? '0 : row;

    assign lb1_q = lb1[cur_col];
    assign lb2_q = lb2[cur_col];

    always_ff @(posedge clk) begin
        if (acc) begin
            lb2[cur_col] <= lb1_q;
            lb1[cur_col] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (acc) begin
            if (cur_col == CW'(IMG_W - 1)) begin
                col <= '0;
                row <= (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + RW'(1);
            end else begin
                col <= cur_col + CW'(1);
                row <= cur_row;
            end
        end
    end

    // Stage 1: window shift and flags for the centre pixel (row-1, col-1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win[i][j] <= '0;
                end
            end
            v1   <= 1'b0;
            sof1 <= 1'b0;
            eol1 <= 1'b0;
        end else if (en) begin
            v1   <= acc && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
            sof1 <= (cur_row == RW'(2)) && (cur_col == CW'(2));
            eol1 <= (cur_col == CW'(IMG_W - 1));
            if (acc) begin
                for (int i = 0; i < 3; i++) begin
                    win[i][0] <= win[i][1];
                    win[i][1] <= win[i][2];
                end
                win[0][2] <= lb2_q;
                win[1][2] <= lb1_q;
                win[2][2] <= s_data;
            end
        end
    end

    // Unsigned sums wrap into a GW-bit two's-complement difference; range fits.
    always_comb begin
        gx     = '0;
        gy     = '0;
        gx_abs = '0;
        gy_abs = '0;
        mag    = '0;
        mag_sh = '0;
        sat    = '0;
        result = '0;
        gx = (GW'(win[0][2]) + (GW'(win[1][2]) << 1) + GW'(win[2][2]))
           - (GW'(win[0][0]) + (GW'(win[1][0]) << 1) + GW'(win[2][0]));
        gy = (GW'(win[2][0]) + (GW'(win[2][1]) << 1) + GW'(win[2][2]))
           - (GW'(win[0][0]) + (GW'(win[0][1]) << 1) + GW'(win[0][2]));
        gx_abs = gx[GW-1] ? (~gx + GW'(1)) : gx;
        gy_abs = gy[GW-1] ? (~gy + GW'(1)) : gy;
        mag    = gx_abs + gy_abs;
        mag_sh = mag >> MAG_SHIFT;
        sat    = (mag_sh > GW'({PIX_W{1'b1}})) ? {PIX_W{1'b1}} : mag_sh[PIX_W-1:0];
`ifdef SOBEL_THRESH_EN
        result = (sat >= thresh) ? {PIX_W{1'b1}} : '0;
`else
        result = sat;
`endif
    end

    // Stage 2: output register, frozen while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sof   <= 1'b0;
            m_eol   <= 1'b0;
        end else if (en) begin
            m_valid <= v1;
            m_data  <= result;
            m_sof   <= v1 && sof1;
            m_eol   <= v1 && eol1;
        end
    end

endmodule
